rsa_modexp_core: RTL and testbench

//  Parametrised modular-exponentiation engine: R = M^E mod N, WIDTH-bit operands.

---
 rtl/rsa_modexp_core.sv | 189 ++++++++++++++++++
 tb/tb_rsa_modexp_core.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/rsa_modexp_core.sv
// rsa_modexp_core: R = M^E mod N over WIDTH-bit operands.
// Byte-wide host port for loading M/E/N and reading any register back.
// Left-to-right square-and-multiply built on a bit-serial interleaved
// modular multiplier; a leading REDUCE pass folds M into [0, N).
module rsa_modexp_core #(
    parameter int WIDTH  = 256,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic              oe,
    input  logic              start,
    input  logic [1:0]        reg_sel,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        data_i,
    output logic [7:0]        data_o,
    output logic              ready,
    output logic              done
);

    localparam int NBYTES = WIDTH / 8;
    localparam int CW     = $clog2(WIDTH);
    localparam logic [CW-1:0] TOP_BIT = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REDUCE,
        S_SQR,
        S_MUL,
        S_DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] m_reg, e_reg, n_reg, r_reg;
    logic [WIDTH-1:0] x_reg;    // running exponentiation result
    logic [WIDTH-1:0] mr_reg;   // M mod N
    logic [WIDTH-1:0] p_reg;    // multiplier / reducer accumulator, always < N
    logic [CW-1:0]    bit_idx;  // operand bit walked by REDUCE/SQR/MUL
    logic [CW-1:0]    exp_idx;  // exponent bit j

    logic [WIDTH:0]   n_ext, dbl, dbl_red, sum, sum_red;
    logic [WIDTH-1:0] a_op, p_next, sel_word;
    logic             b_bit;
    logic [7:0]       rd_byte;

    // One step of the shared datapath: double (plus M bit when reducing),
    // conditionally subtract N, then add A when multiplying and subtract again.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        n_ext   = {1'b0, n_reg};
        b_bit   = (state == S_REDUCE) ? m_reg[bit_idx] : x_reg[bit_idx];
        a_op    = (state == S_MUL) ? mr_reg : x_reg;
        dbl     = (state == S_REDUCE) ? {p_reg, b_bit} : {p_reg, 1'b0};
        dbl_red = (dbl >= n_ext) ? dbl - n_ext : dbl;
        sum     = dbl_red;
        if (state != S_REDUCE && b_bit)
            sum = dbl_red + {1'b0, a_op};
        sum_red = (sum >= n_ext) ? sum - n_ext : sum;
        p_next  = sum_red[WIDTH-1:0];
    end

    // Host-side read mux: byte addr of the selected register, 0 when out of range.
    always_comb begin
        rd_byte = 8'h00;
        case (reg_sel)
            2'd0:    sel_word = r_reg;
            2'd1:    sel_word = m_reg;
            2'd2:    sel_word = e_reg;
            default: sel_word = n_reg;
        endcase
        for (int b = 0; b < NBYTES; b++)
            if (addr == ADDR_W'(b))
                rd_byte = sel_word[b*8 +: 8];
    end

    // Operand byte writes, accepted only while idle and for in-range M/E/N bytes.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: operands are plain flops, not a RAM, so they take the async reset like any other state.
        if (reset) begin
            m_reg <= '0;
            e_reg <= '0;
            n_reg <= '0;
        end else if (!we && ready && reg_sel != 2'd0) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (addr == ADDR_W'(b)) begin
                    case (reg_sel)
                        2'd1:    m_reg[b*8 +: 8] <= data_i;
                        2'd2:    e_reg[b*8 +: 8] <= data_i;
                        default: n_reg[b*8 +: 8] <= data_i;
                    endcase
                end
            end
        end
    end

    // Registered read port; holds its last byte while oe is high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            data_o <= 8'h00;
        else if (!oe)
            data_o <= rd_byte;
    end

    // Sequencer: IDLE -> REDUCE -> (SQR [-> MUL]) per exponent bit -> DONE.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state   <= S_IDLE;
            ready   <= 1'b1;
            done    <= 1'b0;
            r_reg   <= '0;
            x_reg   <= '0;
            mr_reg  <= '0;
            p_reg   <= '0;
            bit_idx <= '0;
            exp_idx <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        ready <= 1'b0;
                        if (n_reg <= WIDTH'(1)) begin
                            x_reg <= '0;
                            state <= S_DONE;
                        end else begin
                            p_reg   <= '0;
                            bit_idx <= TOP_BIT;
                            exp_idx <= TOP_BIT;
                            state   <= S_REDUCE;
                        end
                    end
                end
                S_REDUCE: begin
                    p_reg   <= p_next;
                    bit_idx <= bit_idx - 1'b1;
                    if (bit_idx == '0) begin
                        mr_reg  <= p_next;
                        x_reg   <= WIDTH'(1);
                        p_reg   <= '0;
                        bit_idx <= TOP_BIT;
                        state   <= S_SQR;
                    end
                end
                S_SQR: begin
                    p_reg   <= p_next;
                    bit_idx <= bit_idx - 1'b1;
                    if (bit_idx == '0) begin
                        x_reg   <= p_next;
                        p_reg   <= '0;
                        bit_idx <= TOP_BIT;
                        if (e_reg[exp_idx])
                            state <= S_MUL;
                        else if (exp_idx == '0)
                            state <= S_DONE;
                        else begin
                            exp_idx <= exp_idx - 1'b1;
                            state   <= S_SQR;
                        end
                    end
                end
                S_MUL: begin
                    p_reg   <= p_next;
                    bit_idx <= bit_idx - 1'b1;
                    if (bit_idx == '0) begin
                        x_reg   <= p_next;
                        p_reg   <= '0;
                        bit_idx <= TOP_BIT;
                        if (exp_idx == '0)
                            state <= S_DONE;
                        else begin
                            exp_idx <= exp_idx - 1'b1;
                            state   <= S_SQR;
                        end
                    end
                end
                S_DONE: begin
                    r_reg <= x_reg;
                    done  <= 1'b1;
                    ready <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_modexp_core.sv
// Directed bench for rsa_modexp_core at WIDTH=16: hand-computed results,
// exact busy latency, host-port edge cases, and mid-run reset.
module tb_rsa_modexp_core;

    localparam int WIDTH  = 16;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              we = 1'b1;
    logic              oe = 1'b1;
    logic              start = 1'b0;
    logic [1:0]        reg_sel = 2'd0;
    logic [ADDR_W-1:0] addr = '0;
    logic [7:0]        data_i = 8'h00;
    logic [7:0]        data_o;
    logic              ready;
    logic              done;

    int n_vec = 0;
    int n_err = 0;

    rsa_modexp_core #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .we      (we),
        .oe      (oe),
        .start   (start),
        .reg_sel (reg_sel),
        .addr    (addr),
        .data_i  (data_i),
        .data_o  (data_o),
        .ready   (ready),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled #1 after the rising edge.
    task automatic write_byte(input logic [1:0] sel, input logic [ADDR_W-1:0] a, input logic [7:0] d);
        @(negedge clk);
        we = 1'b0; reg_sel = sel; addr = a; data_i = d;
        @(negedge clk);
        we = 1'b1;
    endtask

    task automatic read_byte(input logic [1:0] sel, input logic [ADDR_W-1:0] a, output logic [7:0] d);
        @(negedge clk);
        oe = 1'b0; reg_sel = sel; addr = a;
        @(posedge clk);
        #1 d = data_o;
        @(negedge clk);
        oe = 1'b1;
    endtask

    task automatic load(input logic [15:0] n, input logic [15:0] m, input logic [15:0] e);
        write_byte(2'd3, 0, n[7:0]);  write_byte(2'd3, 1, n[15:8]);
        write_byte(2'd1, 0, m[7:0]);  write_byte(2'd1, 1, m[15:8]);
        write_byte(2'd2, 0, e[7:0]);  write_byte(2'd2, 1, e[15:8]);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Wait for ready with a cycle budget; returns busy length and done count.
    task automatic wait_ready(output int cycles, output int dones);
        int budget;
        cycles = 1;
        dones  = 0;
        budget = 2000;
        while (!ready && budget > 0) begin
            @(posedge clk);
            #1;
            if (done) dones++;
            if (!ready) cycles++;
            budget--;
        end
        if (!ready) check("ready_timeout", 32'(ready), 32'd1);
    endtask

    task automatic run_case(input string tag, input logic [15:0] n, input logic [15:0] m,
                            input logic [15:0] e, input logic [15:0] r_exp, input int lat_exp);
        int cyc, dn;
        logic [7:0] lo, hi;
        load(n, m, e);
        pulse_start();
        check({tag, "_busy"}, 32'(ready), 32'd0);
        wait_ready(cyc, dn);
        check({tag, "_latency"}, 32'(cyc), 32'(lat_exp));
        check({tag, "_done_cnt"}, 32'(dn), 32'd1);
        @(posedge clk);
        #1 check({tag, "_done_drop"}, 32'(done), 32'd0);
        read_byte(2'd0, 0, lo);
        read_byte(2'd0, 1, hi);
        check({tag, "_r"}, 32'({hi, lo}), 32'(r_exp));
    endtask

    initial begin
        logic [7:0] d;
        int cyc, dn;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_data_o", 32'(data_o), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int s = 0; s < 4; s++)
            for (int a = 0; a < 2; a++) begin
                read_byte(2'(s), ADDR_W'(a), d);
                check($sformatf("rst_reg%0d_b%0d", s, a), 32'(d), 32'd0);
            end

        // Main function: 88^7 mod 187 = 11, latency 16*(1+16+3)+1
        run_case("v88_7", 16'h00BB, 16'h0058, 16'h0007, 16'h000B, 321);

        // Busy-time behaviour: writes and start ignored, R reads old result
        pulse_start();
        write_byte(2'd1, 0, 8'h00);
        pulse_start();
        read_byte(2'd0, 0, d);
        check("busy_r_old", 32'(d), 32'h0B);
        wait_ready(cyc, dn);
        check("busy_done_cnt", 32'(dn), 32'd1);
        read_byte(2'd0, 0, d);
        check("busy_final_r", 32'(d), 32'h0B);
        read_byte(2'd1, 0, d);
        check("busy_m_kept", 32'(d), 32'h58);
        // data_o holds with oe high
        @(posedge clk); @(posedge clk);
        #1 check("data_o_hold", 32'(data_o), 32'h58);

        // M >= N, zero exponent, trivial modulus, larger moduli
        run_case("m_ge_n", 16'h0007, 16'h00FF, 16'h0002, 16'h0002, 289);
        run_case("e_zero", 16'h0007, 16'h00FF, 16'h0000, 16'h0001, 273);
        run_case("n_one", 16'h0001, 16'h00FF, 16'h0002, 16'h0000, 1);
        run_case("v241", 16'h00F1, 16'h1234, 16'h0003, 16'h0024, 305);
        run_case("vneg1", 16'hFFF1, 16'hFFF0, 16'h0003, 16'hFFF0, 305);
        run_case("v2_16", 16'hFFF1, 16'h0002, 16'h0010, 16'h000F, 289);

        // Reset 100 cycles into a run
        load(16'h00BB, 16'h0058, 16'h0007);
        pulse_start();
        repeat (100) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 check("mid_rst_ready", 32'(ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        dn = 0;
        repeat (400) begin
            @(posedge clk);
            #1 if (done) dn++;
        end
        check("mid_rst_no_done", 32'(dn), 32'd0);
        for (int s = 0; s < 4; s++)
            for (int a = 0; a < 2; a++) begin
                read_byte(2'(s), ADDR_W'(a), d);
                check($sformatf("mid_rst_reg%0d_b%0d", s, a), 32'(d), 32'd0);
            end

        // Out-of-range addresses and writes to R
        write_byte(2'd1, 2, 8'hAA);
        write_byte(2'd1, 31, 8'h55);
        write_byte(2'd0, 0, 8'h77);
        read_byte(2'd1, 2, d);   check("oor_a2", 32'(d), 32'd0);
        read_byte(2'd1, 31, d);  check("oor_a31", 32'(d), 32'd0);
        read_byte(2'd1, 0, d);   check("oor_m_b0", 32'(d), 32'd0);
        read_byte(2'd1, 1, d);   check("oor_m_b1", 32'(d), 32'd0);
        read_byte(2'd0, 0, d);   check("r_readonly", 32'(d), 32'd0);

        // Simultaneous write and read of M byte 0
        write_byte(2'd1, 0, 8'h5A);
        @(negedge clk);
        we = 1'b0; oe = 1'b0; reg_sel = 2'd1; addr = 0; data_i = 8'hC3;
        @(posedge clk);
        #1 check("wr_rd_old", 32'(data_o), 32'h5A);
        @(negedge clk);
        we = 1'b1; oe = 1'b1;
        read_byte(2'd1, 0, d);
        check("wr_rd_new", 32'(d), 32'hC3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
